// File: rtl/ring_buf_reader.sv
// ---------------------------------------------------------------------------
// ring_buf_reader
//
// Read-side controller for a circular buffer of DEPTH entries. The writer is
// a separate block that publishes its next-write slot (wr_ptr) and a phase bit
// (wr_wrap) that toggles every time its index wraps. This block samples that
// pointer, works out how many entries are waiting, and reads them from a
// synchronous memory with one cycle of read latency. Returned words go into a
// 2-entry output FIFO that drives a valid/ready stream. The read pointer is
// returned to the writer so it can free slots.
//
// Optional build macro: RING_BUF_READER_LEVEL_EN
//   When defined, adds a registered 'level' output: the number of entries not
//   yet delivered downstream (waiting + inflight + buffered).
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_ptr       in   [PTR_W]  writer slot index of next write (0..DEPTH-1)
//   wr_wrap      in   writer phase bit
//   mem_rd_en    out  memory read strobe
//   mem_rd_addr  out  [PTR_W]  memory read address (equals rd_ptr)
//   mem_rd_data  in   [WIDTH]  memory data, valid the cycle after mem_rd_en
//   rd_ptr       out  [PTR_W]  slot index of next read issue
//   rd_wrap      out  reader phase bit
//   m_valid      out  output word valid
//   m_ready      in   downstream accept
//   m_data       out  [WIDTH]  output word (head of output FIFO)
//   empty        out  no unissued entries in the ring
//   level        out  [PTR_W+1] undelivered entries (only with the macro)
// ---------------------------------------------------------------------------
`default_nettype none

module ring_buf_reader #(
  parameter  int DEPTH = 20,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic             wr_wrap,
  output logic             mem_rd_en,
  output logic [PTR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             rd_wrap,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             empty
`ifdef RING_BUF_READER_LEVEL_EN
  ,
  output logic [PTR_W:0]   level
`endif
);

  // Next slot index around a ring that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Entries between reader and writer. Equal indices with opposite phase is
  // a full ring (DEPTH entries), which is why the result is one bit wider.
  function automatic logic [PTR_W:0] ring_avail(input logic [PTR_W-1:0] wp,
                                                input logic             ww,
                                                input logic [PTR_W-1:0] rp,
                                                input logic             rw);
    if (ww == rw)
      ring_avail = {1'b0, wp} - {1'b0, rp};
    else
      ring_avail = (PTR_W+1)'(DEPTH) - {1'b0, rp} + {1'b0, wp};
  endfunction

  logic [PTR_W-1:0] wr_ptr_p0;
  logic             wr_wrap_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] obuf0_p2;
  logic [WIDTH-1:0] obuf1_p2;
  logic [1:0]       cnt_p2;

  logic [PTR_W:0]   avail;
  logic [2:0]       occ;
  logic             pop;

  // ---- p0: writer pointer sync stage -------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0  <= '0;
      wr_wrap_p0 <= 1'b0;
    end else begin
      wr_ptr_p0  <= wr_ptr;
      wr_wrap_p0 <= wr_wrap;
    end
  end

  assign avail = ring_avail(wr_ptr_p0, wr_wrap_p0, rd_ptr, rd_wrap);
  assign empty = (wr_ptr_p0 == rd_ptr) && (wr_wrap_p0 == rd_wrap);

  // Credit: buffered words plus the one in flight must leave room in the
  // 2-entry FIFO. A word leaving this cycle frees a slot in time for the new
  // read's data, which is what lets the stream run at one word per cycle.
  assign occ       = {1'b0, cnt_p2} + {2'b00, vld_p1};
  assign pop       = m_valid && m_ready;
  assign mem_rd_en = (avail != '0) && (occ < (3'd2 + {2'b00, pop}));
  assign mem_rd_addr = rd_ptr;

  // ---- p1: read issue / inflight -----------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_wrap <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= mem_rd_en;
      if (mem_rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
        if (rd_ptr == PTR_W'(DEPTH - 1))
          rd_wrap <= ~rd_wrap;
      end
    end
  end

  // ---- p2: 2-entry output FIFO, entry 0 is the head ----------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf0_p2 <= '0;
      obuf1_p2 <= '0;
      cnt_p2   <= 2'd0;
    end else begin
      case ({vld_p1, pop})
        2'b10: begin
          if (cnt_p2 == 2'd0)
            obuf0_p2 <= mem_rd_data;
          else
            obuf1_p2 <= mem_rd_data;
          cnt_p2 <= cnt_p2 + 2'd1;
        end
        2'b01: begin
          obuf0_p2 <= obuf1_p2;
          cnt_p2   <= cnt_p2 - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt_p2 == 2'd1) begin
            obuf0_p2 <= mem_rd_data;
          end else begin
            obuf0_p2 <= obuf1_p2;
            obuf1_p2 <= mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid = (cnt_p2 != 2'd0);
  assign m_data  = obuf0_p2;

`ifdef RING_BUF_READER_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      level <= '0;
    else
      level <= avail + (PTR_W+1)'(cnt_p2) + (PTR_W+1)'(vld_p1);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ring_buf_reader.sv
// ---------------------------------------------------------------------------
// Bench for ring_buf_reader. The writer and reader are modelled as plain
// running totals of slots written / claimed / delivered; ring indices and
// phase bits are derived from those totals with modulo arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ring_buf_reader;
  localparam int DEPTH = 20;
  localparam int WIDTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_wrap;
  logic             mem_rd_en;
  logic [PTR_W-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data = '0;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_wrap;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             empty;
`ifdef RING_BUF_READER_LEVEL_EN
  logic [PTR_W:0]   level;
`endif

  ring_buf_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ptr     (wr_ptr),
    .wr_wrap    (wr_wrap),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .rd_ptr     (rd_ptr),
    .rd_wrap    (rd_wrap),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .empty      (empty)
`ifdef RING_BUF_READER_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents are fixed random words; slot s always holds mem[s].
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Writer: total slots ever written since reset.
  int unsigned w_tot = 0;
  int unsigned wq_tot = 0;   // writer total as seen by the reader after sync
  assign wr_ptr  = PTR_W'(w_tot % DEPTH);
  assign wr_wrap = ((w_tot / DEPTH) % 2) == 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) wq_tot <= 0;
    else        wq_tot <= w_tot;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint unsigned obs,
                     input longint unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: totals of reads claimed and words delivered, plus a queue
  // of words expected downstream in order.
  int unsigned      r_tot = 0;
  int unsigned      acc_tot = 0;
  bit               last_iss = 0;
  logic [WIDTH-1:0] expq[$];
  int unsigned      addr_log[$];
  int unsigned      outst, avail_m;
  bit               exp_vld, exp_pop, exp_en;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_tot = 0; acc_tot = 0; last_iss = 0;
      expq.delete();
    end else begin
      outst   = r_tot - acc_tot;
      avail_m = wq_tot - r_tot;
      exp_vld = (outst - (last_iss ? 1 : 0)) != 0;
      exp_pop = exp_vld && m_ready;
      exp_en  = (avail_m != 0) && ((outst - (exp_pop ? 1 : 0)) < 2);
      chk("m_valid", m_valid, exp_vld);
      chk("mem_rd_en", mem_rd_en, exp_en);
      chk("empty", empty, avail_m == 0);
      chk("rd_ptr", rd_ptr, r_tot % DEPTH);
      chk("rd_wrap", rd_wrap, (r_tot / DEPTH) % 2);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("pop_unexpected", 1, 0);
        else begin
          chk("m_data", m_data, expq.pop_front());
          acc_tot++;
        end
      end
      if (mem_rd_en) begin
        chk("rd_addr", mem_rd_addr, r_tot % DEPTH);
        expq.push_back(mem[r_tot % DEPTH]);
        addr_log.push_back(mem_rd_addr);
        r_tot++;
      end
      last_iss = mem_rd_en;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; w_tot = 0; m_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (r_tot == w_tot && acc_tot == r_tot && expq.size() == 0) begin
        done = 1;
        break;
      end
      step();
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    rst_n = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_rd_wrap", rd_wrap, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_empty", empty, 1);
    rst_n = 1'b1;
    step(); step();

    // Three entries: latency and ordering
    m_ready = 1'b1;
    w_tot = 3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_en_latency", mem_rd_en, k >= 1);
      chk("t1_vld_latency", m_valid, k == 3);
      if (k == 3) chk("t1_first_word", m_data, mem[0]);
    end
    step();
    drain("t1_drain");
    chk("t1_rd_ptr", rd_ptr, 3);
    chk("t1_empty", empty, 1);
    chk("t1_words", acc_tot, 3);

    // Wrap from 18 through 0 to 5 with phase toggle
    w_tot = 18;
    step();
    drain("t2_pre_drain");
    addr_log.delete();
    w_tot = 25;
    step();
    drain("t2_drain");
    chk("t2_nreads", addr_log.size(), 7);
    for (int i = 0; i < 7 && i < addr_log.size(); i++)
      chk("t2_addr", addr_log[i], (18 + i) % DEPTH);
    chk("t2_rd_ptr", rd_ptr, 5);
    chk("t2_rd_wrap", rd_wrap, 1);

    // Full ring under backpressure, then back-to-back stream
    do_reset();
    w_tot = DEPTH;
    repeat (10) step();
    chk("t3_reads", r_tot, 2);
    chk("t3_vld", m_valid, 1);
    chk("t3_head", m_data, mem[0]);
    chk("t3_full_not_empty", empty, 0);
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t3_stream_vld", m_valid, 1);
    end
    step();
    chk("t3_words", acc_tot, DEPTH);
    chk("t3_empty", empty, 1);

    // Toggling ready with 8 entries
    w_tot = DEPTH + 8;
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2) == 0;
      step();
    end
    drain("t4_drain");
    chk("t4_words", acc_tot, DEPTH + 8);

    // Randomised writer and downstream ready
    for (int i = 0; i < 800; i++) begin
      m_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0)
        w_tot = w_tot + $urandom_range(0, DEPTH - (w_tot - r_tot));
      step();
    end
    drain("rand_drain");
    chk("rand_words", acc_tot, w_tot);

    // Reset with words buffered and inflight
    do_reset();
    w_tot = 5;
    repeat (3) step();
    chk("t5_pre_vld", m_valid, 1);
    chk("t5_pre_inflight", r_tot - acc_tot, 2);
    rst_n = 1'b0;
    w_tot = 0;
    #1;
    chk("t5_rst_vld", m_valid, 0);
    chk("t5_rst_rd_ptr", rd_ptr, 0);
    chk("t5_rst_en", mem_rd_en, 0);
    step(); step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_no_rd", mem_rd_en, 0);
      chk("t5_no_vld", m_valid, 0);
    end

`ifdef RING_BUF_READER_LEVEL_EN
    // Level holds at the waiting count while entries move into the buffer
    do_reset();
    chk("lvl_rst", level, 0);
    w_tot = 7;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 2) chk("lvl_hold", level, 7);
    end
    step();
    drain("lvl_drain");
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
